// File: rtl/text_console_if.sv
// Character input handshake and renderer read port of the text console.
// The character source drives ch_*, the renderer drives rd_row/rd_col and receives rd_char.
interface text_console_if #(
  parameter int COLS = 70,
  parameter int ROWS = 30
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic          ch_valid;
  logic [7:0]    ch_data;
  logic          ch_ready;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] rd_row;
  logic [7:0]    rd_char;

  modport master (output ch_valid, ch_data, rd_col, rd_row, input ch_ready, rd_char);
  modport slave  (input ch_valid, ch_data, rd_col, rd_row, output ch_ready, rd_char);
endinterface

// File: rtl/text_console.sv
// COLS x ROWS character terminal: cursor, line wrap, cross-line backspace, scroll; 1-cycle read port.
// One char per cycle in IDLE; ch_ready drops during INIT (COLS*ROWS cycles) and SCROLL (COLS cycles).
module text_console #(
  parameter  int COLS       = 70,
  parameter  int ROWS       = 30,
  parameter  int BLINK_HALF = 12_500_000,
  localparam int CW         = $clog2(COLS),
  localparam int RW         = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  text_console_if.slave bus,
  output logic [CW-1:0] cur_col,
  output logic [RW-1:0] cur_row,
  output logic [RW-1:0] top_row,
  output logic          cur_blink,
  output logic          busy
);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);
  localparam int LW = $clog2(COLS + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {INIT, IDLE, SCROLL} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] top_q, top_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [7:0]    rd_char_q;

  logic [7:0]    mem [N];
  logic [LW-1:0] len_q [ROWS];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          len_we;
  logic [LW-1:0] len_wval;
  logic          acc;
  logic          advance;
  logic [RW-1:0] cur_phys;
  logic [RW-1:0] prev_phys;
  logic [LW-1:0] prev_len;
  logic          rd_ok;
  logic [AW-1:0] rd_addr;

  function automatic logic [RW-1:0] phys(input logic [RW-1:0] top, input logic [RW-1:0] r);
    logic [RW:0] s;
    s = {1'b0, top} + {1'b0, r};
    if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] addr(input logic [RW-1:0] p, input logic [CW-1:0] c);
    return AW'(p) * AW'(COLS) + AW'(c);
  endfunction

  assign acc       = bus.ch_valid && (state_q == IDLE);
  assign cur_phys  = phys(top_q, row_q);
  assign prev_phys = phys(top_q, row_q - RW'(1));
  assign prev_len  = len_q[prev_phys];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    top_d     = top_q;
    mem_we    = 1'b0;
    mem_waddr = addr(cur_phys, col_q);
    mem_wdata = 8'h00;
    len_we    = 1'b0;
    len_wval  = '0;
    advance   = 1'b0;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        if (cnt_q == AW'(N - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      // top_q already points past the old top, so cur_phys is the freshly exposed row
      SCROLL: begin
        mem_we    = 1'b1;
        mem_waddr = addr(cur_phys, CW'(cnt_q));
        if (cnt_q == AW'(COLS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      IDLE: begin
        if (acc) begin
          if (bus.ch_data >= 8'h20 && bus.ch_data <= 8'h7E) begin
            mem_we    = 1'b1;
            mem_wdata = bus.ch_data;
            if (col_q < CW'(COLS - 1)) begin
              col_d = col_q + CW'(1);
            end else begin
              len_we   = 1'b1;
              len_wval = LW'(COLS);
              col_d    = '0;
              advance  = 1'b1;
            end
          end else if (bus.ch_data == 8'h0A || bus.ch_data == 8'h0D) begin
            len_we   = 1'b1;
            len_wval = LW'(col_q);
            col_d    = '0;
            advance  = 1'b1;
          end else if (bus.ch_data == 8'h08) begin
            if (col_q != '0) begin
              col_d     = col_q - CW'(1);
              mem_we    = 1'b1;
              mem_waddr = addr(cur_phys, col_q - CW'(1));
            end else if (row_q != '0) begin
              row_d = row_q - RW'(1);
              // a full-length line was wrapped: erase its last cell instead of landing after it
              if (prev_len == LW'(COLS)) begin
                col_d     = CW'(COLS - 1);
                mem_we    = 1'b1;
                mem_waddr = addr(prev_phys, CW'(COLS - 1));
              end else begin
                col_d = CW'(prev_len);
              end
            end
          end
          if (advance) begin
            if (row_q < RW'(ROWS - 1)) begin
              row_d = row_q + RW'(1);
            end else begin
              top_d   = (top_q == RW'(ROWS - 1)) ? '0 : top_q + RW'(1);
              state_d = SCROLL;
              cnt_d   = '0;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase

    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (acc) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      top_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      for (int i = 0; i < ROWS; i++) len_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      top_q       <= top_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      if (len_we) len_q[cur_phys] <= len_wval;
      if (state_q == SCROLL) len_q[cur_phys] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_ok   = ({1'b0, bus.rd_col} < (CW+1)'(COLS)) && ({1'b0, bus.rd_row} < (RW+1)'(ROWS));
  assign rd_addr = rd_ok ? addr(phys(top_q, bus.rd_row), bus.rd_col) : '0;

  always_ff @(posedge clk) begin
    if (reset || state_q == INIT || !rd_ok) rd_char_q <= 8'h00;
    else                                    rd_char_q <= mem[rd_addr];
  end

  assign bus.ch_ready = (state_q == IDLE);
  assign bus.rd_char  = rd_char_q;
  assign busy         = (state_q != IDLE);
  assign cur_col      = col_q;
  assign cur_row      = row_q;
  assign top_row      = top_q;
  assign cur_blink    = blink_q;
endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console (4x3, blink half-period 8); read responses go through a scoreboard.
module tb_text_console;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int BH   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cur_col;
  logic [1:0] cur_row;
  logic [1:0] top_row;
  logic       cur_blink;
  logic       busy;

  text_console_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  text_console #(.COLS(COLS), .ROWS(ROWS), .BLINK_HALF(BH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .top_row  (top_row),
    .cur_blink(cur_blink),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int      n_chk  = 0;
  int      n_pass = 0;
  logic    rd_req = 1'b0;
  logic    rd_req_d = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // monitor: a read issued before a rising edge is answered at the following falling edge
  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (rd_req_d) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk(e.name, int'(bus.rd_char), int'(e.exp));
      end
    end
  end

  task automatic rd(input int r, input int c, input int e, input string nm);
    rd_exp_t x;
    x.exp  = 8'(e);
    x.name = nm;
    exp_q.push_back(x);
    bus.rd_row = 2'(r);
    bus.rd_col = 2'(c);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    bus.ch_valid = 1'b1;
    bus.ch_data  = c;
    while (!bus.ch_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ch_ready) chk("send_timeout", 0, 1);
    else @(negedge clk);
    bus.ch_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic cursor(input int r, input int c, input string nm);
    chk({nm, "_row"}, int'(cur_row), r);
    chk({nm, "_col"}, int'(cur_col), c);
  endtask

  task automatic count_low(input string nm, input int exp);
    int n = 0;
    while (!bus.ch_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, exp);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    bus.ch_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cursor(0, 0, nm);
    chk({nm, "_top"}, int'(top_row), 0);
    chk({nm, "_blink"}, int'(cur_blink), 1);
    chk({nm, "_busy"}, int'(busy), 1);
    chk({nm, "_ready"}, int'(bus.ch_ready), 0);
    chk({nm, "_rdchar"}, int'(bus.rd_char), 0);
    reset = 1'b0;
  endtask

  task automatic read_all_zero(input string nm);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        rd(r, c, 0, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;
    bus.rd_row   = '0;
    bus.rd_col   = '0;

    // power-up clear
    do_reset("rst0");
    count_low("init_cycles", 12);
    read_all_zero("init_clr");

    // wrap then backspace back across the wrap
    send_str("ABCDE");
    cursor(1, 1, "wrap");
    rd(0, 0, 8'h41, "wrap_r0c0");
    rd(0, 1, 8'h42, "wrap_r0c1");
    rd(0, 2, 8'h43, "wrap_r0c2");
    rd(0, 3, 8'h44, "wrap_r0c3");
    rd(1, 0, 8'h45, "wrap_r1c0");
    send(8'h08);
    cursor(1, 0, "bs1");
    send(8'h08);
    cursor(0, 3, "bs_wrap");
    rd(0, 3, 0, "bs_clr_D");
    rd(0, 2, 8'h43, "bs_keep_C");
    rd(1, 0, 0, "bs_clr_E");

    // backspace over a short line, then the (0,0) floor
    do_reset("rst1");
    count_low("init2_cycles", 12);
    send_str("AB");
    send(8'h0D);
    cursor(1, 0, "cr");
    send(8'h08);
    cursor(0, 2, "bs_len");
    rd(0, 1, 8'h42, "bs_nowrite");
    send(8'h08);
    cursor(0, 1, "bs_col");
    rd(0, 1, 0, "bs_clr_B");
    rd(0, 0, 8'h41, "bs_keep_A");
    repeat (5) send(8'h08);
    cursor(0, 0, "floor");
    rd(0, 0, 0, "floor_clr");
    send(8'h01);
    send(8'h7F);
    cursor(0, 0, "ignored");

    // scroll on the third newline
    send_str("PQ");
    send(8'h0D);
    send(8'h52);
    send(8'h0D);
    send(8'h53);
    cursor(2, 1, "pre_scroll");
    send(8'h0D);
    count_low("scroll_cycles", 4);
    chk("scroll_top", int'(top_row), 1);
    chk("scroll_busy", int'(busy), 0);
    cursor(2, 0, "scroll");
    rd(0, 0, 8'h52, "scr_r0");
    rd(1, 0, 8'h53, "scr_r1");
    for (int c = 0; c < COLS; c++) rd(2, c, 0, "scr_new_row");
    send(8'h08);
    cursor(1, 1, "bs_scrolled");

    // read and write of the same cell in one cycle, then blink timing
    bus.ch_valid = 1'b1;
    bus.ch_data  = 8'h5A;
    rd(1, 1, 0, "rw_old");
    bus.ch_valid = 1'b0;
    chk("blink_accept", int'(cur_blink), 1);
    repeat (7) @(negedge clk);
    chk("blink_hold", int'(cur_blink), 1);
    @(negedge clk);
    chk("blink_toggle", int'(cur_blink), 0);
    rd(1, 1, 8'h5A, "rw_new");
    send(8'h58);
    chk("blink_restart", int'(cur_blink), 1);
    repeat (7) @(negedge clk);
    chk("blink_restart_hold", int'(cur_blink), 1);
    cursor(1, 3, "after_x");

    // reset in the middle of a scroll
    send(8'h0D);
    send(8'h0D);
    @(negedge clk);
    chk("mid_scroll_busy", int'(busy), 1);
    do_reset("rst_mid");
    count_low("init3_cycles", 12);
    chk("reinit_top", int'(top_row), 0);
    read_all_zero("reinit_clr");

    repeat (2) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
